// File: rtl/event_pkg.sv
// Event-report message definitions shared by the event reporter and the event decoder.
package event_pkg;
  localparam int CLASS_W = 8;
  localparam int ID_W    = 8;

  localparam logic [CLASS_W-1:0] MSG_CLASS_EVENT = 8'h01;
  localparam logic [ID_W-1:0]    EVT_UNDERFLOW   = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READY  = 2'd1,
    S_UPDATE = 2'd2
  } dec_state_t;

  // Event IDs are 1-based; ID 0 is never a valid event.
  function automatic logic id_in_range(input logic [ID_W-1:0] id, input int num_events);
    return (id != '0) && (int'(id) <= num_events);
  endfunction
endpackage

// File: rtl/event_decoder_if.sv
// AXI-stream style event-report link: reporter drives master, decoder receives on slave.
interface event_decoder_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] AXIS_IN_TDATA;
  logic                  AXIS_IN_TVALID;
  logic                  AXIS_IN_TREADY;

  modport master (output AXIS_IN_TDATA, output AXIS_IN_TVALID, input AXIS_IN_TREADY);
  modport slave  (input AXIS_IN_TDATA, input AXIS_IN_TVALID, output AXIS_IN_TREADY);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with increment yields 1.
// Single-cycle update, no backpressure.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_inc ? WIDTH'(1) : '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/event_decoder.sv
// Event-report sink: validates class, decodes ID into strobes, counters, sticky pending and irq.
// One message per 2 clocks (TREADY low during update); EVENT_DECODER_TIMESTAMP_EN adds last-event capture.
module event_decoder
  import event_pkg::*;
#(
  parameter int DATA_WIDTH  = 256,
  parameter int NUM_EVENTS  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  event_decoder_if.slave                  axis,
  input  logic [NUM_EVENTS-1:0]           irq_enable,
  input  logic [NUM_EVENTS-1:0]           pending_clear,
  input  logic                            counter_clear,
  output logic [NUM_EVENTS-1:0]           event_strobe,
  output logic [NUM_EVENTS-1:0]           event_pending,
  output logic [NUM_EVENTS*COUNT_WIDTH-1:0] event_count,
  output logic [COUNT_WIDTH-1:0]          bad_msg_count,
  output logic                            irq
`ifdef EVENT_DECODER_TIMESTAMP_EN
  ,
  output logic [7:0]                      last_event_id,
  output logic [31:0]                     last_event_time
`endif
);
  dec_state_t            r_state;
  logic                  r_tready;
  logic [CLASS_W-1:0]    r_class;
  logic [ID_W-1:0]       r_id;
  logic [NUM_EVENTS-1:0] r_strobe;
  logic [NUM_EVENTS-1:0] r_pending;
  logic                  r_irq;

  logic                  w_update;
  logic                  w_msg_ok;
  logic                  w_bad_inc;
  logic [NUM_EVENTS-1:0] w_evt_inc;
  logic                  w_unused_tdata;

  assign w_update  = (r_state == S_UPDATE);
  assign w_msg_ok  = w_update && (r_class == MSG_CLASS_EVENT) && id_in_range(r_id, NUM_EVENTS);
  assign w_bad_inc = w_update && !w_msg_ok;

  always_comb begin
    w_evt_inc = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      w_evt_inc[i] = w_msg_ok && (r_id == ID_W'(i + 1));
    end
  end

  // Only class and ID are meaningful; the payload between them is ignored.
  assign w_unused_tdata = ^axis.AXIS_IN_TDATA;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tready <= 1'b0;
      r_class  <= '0;
      r_id     <= '0;
      r_strobe <= '0;
    end else begin
      r_strobe <= '0;
      case (r_state)
        S_IDLE: begin
          r_tready <= 1'b1;
          r_state  <= S_READY;
        end
        S_READY: begin
          if (axis.AXIS_IN_TVALID && r_tready) begin
            r_class  <= axis.AXIS_IN_TDATA[DATA_WIDTH-1 -: CLASS_W];
            r_id     <= axis.AXIS_IN_TDATA[ID_W-1:0];
            r_tready <= 1'b0;
            r_state  <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_strobe <= w_evt_inc;
          r_tready <= 1'b1;
          r_state  <= S_READY;
        end
        default: begin
          r_tready <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Set beats clear so an event arriving with a host clear is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~pending_clear) | w_evt_inc;
      r_irq     <= |(r_pending & irq_enable);
    end
  end

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_evt_cnt
    sat_counter #(.WIDTH(COUNT_WIDTH)) u_evt_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_evt_inc[g]),
      .i_clr   (counter_clear),
      .o_count (event_count[g*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_bad_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_bad_inc),
    .i_clr   (counter_clear),
    .o_count (bad_msg_count)
  );

`ifdef EVENT_DECODER_TIMESTAMP_EN
  logic [31:0]     r_timestamp;
  logic [ID_W-1:0] r_last_id;
  logic [31:0]     r_last_time;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timestamp <= '0;
      r_last_id   <= '0;
      r_last_time <= '0;
    end else begin
      r_timestamp <= r_timestamp + 32'd1;
      if (w_msg_ok) begin
        r_last_id   <= r_id;
        r_last_time <= r_timestamp;
      end
    end
  end

  assign last_event_id   = r_last_id;
  assign last_event_time = r_last_time;
`endif

  assign axis.AXIS_IN_TREADY = r_tready;
  assign event_strobe        = r_strobe;
  assign event_pending       = r_pending;
  assign irq                 = r_irq;
endmodule

// File: tb/tb_event_decoder.sv
// Self-checking bench for event_decoder: directed table, corner sequences and randomized traffic vs. a model.
module tb_event_decoder;
  localparam int DW   = 256;
  localparam int NE   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  event_decoder_if #(.DATA_WIDTH(DW)) axis_if ();

  logic [NE-1:0]    irq_enable;
  logic [NE-1:0]    pending_clear;
  logic             counter_clear;
  logic [NE-1:0]    event_strobe;
  logic [NE-1:0]    event_pending;
  logic [NE*CW-1:0] event_count;
  logic [CW-1:0]    bad_msg_count;
  logic             irq;
`ifdef EVENT_DECODER_TIMESTAMP_EN
  logic [7:0]       last_event_id;
  logic [31:0]      last_event_time;
`endif

  event_decoder #(.DATA_WIDTH(DW), .NUM_EVENTS(NE), .COUNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .axis          (axis_if),
    .irq_enable    (irq_enable),
    .pending_clear (pending_clear),
    .counter_clear (counter_clear),
    .event_strobe  (event_strobe),
    .event_pending (event_pending),
    .event_count   (event_count),
    .bad_msg_count (bad_msg_count),
    .irq           (irq)
`ifdef EVENT_DECODER_TIMESTAMP_EN
    ,
    .last_event_id   (last_event_id),
    .last_event_time (last_event_time)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: what the host should observe after each clock edge.
  int            m_cnt[NE];
  int            m_bad;
  logic [NE-1:0] m_pend, m_strobe;
  logic          m_irq, m_ready, m_busy, m_fresh;
  logic [7:0]    m_cls, m_id;
  logic [31:0]   m_ts, m_ltime;
  logic [7:0]    m_lid;
  logic [NE-1:0] seen_strobe;

  typedef struct {
    logic [7:0]    cls;
    logic [7:0]    id;
    logic [NE-1:0] exp_strobe;
    int            exp_bad;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nxt_cnt(input int c, input bit inc, input bit clr);
    if (clr) return inc ? 1 : 0;
    if (inc) return (c + 1 > CMAX) ? CMAX : c + 1;
    return c;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [7:0] c, input logic [7:0] id);
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    d[DW-1 -: 8] = c;
    d[7:0]       = id;
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) m_cnt[i] = 0;
    m_bad = 0; m_pend = '0; m_strobe = '0; m_irq = 1'b0;
    m_ready = 1'b0; m_busy = 1'b0; m_fresh = 1'b1;
    m_cls = '0; m_id = '0; m_ts = '0; m_ltime = '0; m_lid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    axis_if.AXIS_IN_TVALID = 1'b0;
    axis_if.AXIS_IN_TDATA  = '0;
    pending_clear = '0; counter_clear = 1'b0; irq_enable = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  // Advance one clock: predict the edge from current inputs, then compare every output.
  task automatic step();
    logic [7:0]       cls, id;
    logic             upd_ok;
    logic [NE-1:0]    set_v;
    logic [NE*CW-1:0] exp_cnt;
    cls    = axis_if.AXIS_IN_TDATA[DW-1 -: 8];
    id     = axis_if.AXIS_IN_TDATA[7:0];
    set_v  = '0;
    upd_ok = 1'b0;
    if (m_busy) begin
      upd_ok = (m_cls == 8'h01) && (m_id >= 8'd1) && (int'(m_id) <= NE);
      if (upd_ok) set_v[m_id - 8'd1] = 1'b1;
    end
    for (int i = 0; i < NE; i++) m_cnt[i] = nxt_cnt(m_cnt[i], set_v[i], counter_clear);
    m_bad    = nxt_cnt(m_bad, m_busy && !upd_ok, counter_clear);
    m_irq    = |(m_pend & irq_enable);
    m_pend   = (m_pend & ~pending_clear) | set_v;
    m_strobe = set_v;
    if (upd_ok) begin
      m_lid   = m_id;
      m_ltime = m_ts;
    end
    m_ts = m_ts + 32'd1;
    if (m_fresh) begin
      m_fresh = 1'b0; m_ready = 1'b1;
    end else if (m_busy) begin
      m_busy = 1'b0; m_ready = 1'b1;
    end else if (m_ready && axis_if.AXIS_IN_TVALID) begin
      m_busy = 1'b1; m_ready = 1'b0; m_cls = cls; m_id = id;
    end
    @(posedge clk);
    #1;
    seen_strobe |= event_strobe;
    for (int i = 0; i < NE; i++) exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);
    check("tready",  64'(axis_if.AXIS_IN_TREADY), 64'(m_ready));
    check("strobe",  64'(event_strobe),  64'(m_strobe));
    check("pending", 64'(event_pending), 64'(m_pend));
    check("count",   64'(event_count),   64'(exp_cnt));
    check("bad_cnt", 64'(bad_msg_count), 64'(m_bad));
    check("irq",     64'(irq),           64'(m_irq));
`ifdef EVENT_DECODER_TIMESTAMP_EN
    check("last_id",   64'(last_event_id),   64'(m_lid));
    check("last_time", 64'(last_event_time), 64'(m_ltime));
`endif
  endtask

  // Present a message until the handshake edge; leaves the DUT in its update cycle.
  task automatic send(input logic [7:0] c, input logic [7:0] id);
    bit got;
    got = 1'b0;
    axis_if.AXIS_IN_TVALID = 1'b1;
    axis_if.AXIS_IN_TDATA  = mk(c, id);
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      got = m_busy;
    end
    axis_if.AXIS_IN_TVALID = 1'b0;
    axis_if.AXIS_IN_TDATA  = mk(8'hEE, 8'hEE);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL handshake_timeout: got no accept, expected accept within 8 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  tr_pat, st_pat;
    int          exp_bad;
    logic [31:0] t1;

    axis_if.AXIS_IN_TVALID = 1'b0;
    axis_if.AXIS_IN_TDATA  = '0;
    irq_enable = '0; pending_clear = '0; counter_clear = 1'b0;
    seen_strobe = '0;

    // Reset values while reset is held
    @(posedge clk); #1;
    check("rst_tready",  64'(axis_if.AXIS_IN_TREADY), 64'd0);
    check("rst_strobe",  64'(event_strobe),  64'd0);
    check("rst_pending", 64'(event_pending), 64'd0);
    check("rst_count",   64'(event_count),   64'd0);
    check("rst_bad",     64'(bad_msg_count), 64'd0);
    check("rst_irq",     64'(irq),           64'd0);

    // First message after reset release
    do_reset();
    irq_enable = 8'h01;
    step();
    check("first_tready", 64'(axis_if.AXIS_IN_TREADY), 64'd1);
    send(8'h01, 8'h01);
    check("hs_tready_low", 64'(axis_if.AXIS_IN_TREADY), 64'd0);
    check("hs_no_strobe",  64'(event_strobe), 64'd0);
    step();
    check("first_strobe",  64'(event_strobe), 64'h01);
    check("first_pending", 64'(event_pending), 64'h01);
    check("first_count0",  64'(event_count[CW-1:0]), 64'd1);
    check("first_irq_lag", 64'(irq), 64'd0);
    step();
    check("first_strobe_off", 64'(event_strobe), 64'd0);
    check("first_irq",        64'(irq), 64'd1);

    // Back-to-back ID=3 with TVALID held high
    do_reset();
    step();
    axis_if.AXIS_IN_TVALID = 1'b1;
    axis_if.AXIS_IN_TDATA  = mk(8'h01, 8'h03);
    for (int k = 0; k < 8; k++) begin
      step();
      tr_pat[k] = axis_if.AXIS_IN_TREADY;
      st_pat[k] = event_strobe[2];
    end
    axis_if.AXIS_IN_TVALID = 1'b0;
    check("b2b_tready_pat", 64'(tr_pat), 64'b10101010);
    check("b2b_strobe_pat", 64'(st_pat), 64'b10101010);
    check("b2b_count2",     64'(event_count[2*CW +: CW]), 64'd4);

    // Bad class / ID 0 / ID above range
    do_reset();
    step();
    seen_strobe = '0;
    send(8'h02, 8'h01); step();
    send(8'h01, 8'h00); step();
    send(8'h01, 8'h09); step();
    check("bad_count3",   64'(bad_msg_count), 64'd3);
    check("bad_no_strobe", 64'(seen_strobe), 64'd0);
    check("bad_pending",  64'(event_pending), 64'd0);

    // Table of single messages
    tbl[0] = '{8'h01, 8'h01, 8'h01, 0};
    tbl[1] = '{8'h01, 8'h08, 8'h80, 0};
    tbl[2] = '{8'h01, 8'h03, 8'h04, 0};
    tbl[3] = '{8'h02, 8'h01, 8'h00, 1};
    tbl[4] = '{8'h01, 8'h00, 8'h00, 1};
    tbl[5] = '{8'h01, 8'h09, 8'h00, 1};
    tbl[6] = '{8'hFF, 8'h05, 8'h00, 1};
    tbl[7] = '{8'h00, 8'h00, 8'h00, 1};
    tbl[8] = '{8'h01, 8'hFF, 8'h00, 1};
    tbl[9] = '{8'h01, 8'h05, 8'h10, 0};
    do_reset();
    step();
    exp_bad = 0;
    for (int r = 0; r < 10; r++) begin
      send(tbl[r].cls, tbl[r].id);
      step();
      exp_bad += tbl[r].exp_bad;
      check($sformatf("tbl%0d_strobe", r), 64'(event_strobe), 64'(tbl[r].exp_strobe));
      check($sformatf("tbl%0d_bad", r), 64'(bad_msg_count), 64'(exp_bad));
    end

    // Saturation, then clear coincident with increment
    do_reset();
    step();
    for (int k = 0; k < 17; k++) begin
      send(8'h01, 8'h02);
      step();
    end
    check("sat_count1", 64'(event_count[CW +: CW]), 64'd15);
    send(8'h01, 8'h02);
    counter_clear = 1'b1;
    step();
    counter_clear = 1'b0;
    check("clr_inc_count1", 64'(event_count[CW +: CW]), 64'd1);
    check("clr_other",      64'(event_count[CW-1:0]),  64'd0);

    // Pending set/clear collision, then clear alone
    do_reset();
    irq_enable = 8'h01;
    step();
    send(8'h01, 8'h01);
    pending_clear = 8'h01;
    step();
    check("pend_set_wins", 64'(event_pending[0]), 64'd1);
    step();
    pending_clear = '0;
    check("pend_cleared",  64'(event_pending[0]), 64'd0);
    check("pend_irq_high", 64'(irq), 64'd1);
    step();
    check("pend_irq_drop", 64'(irq), 64'd0);

    // Reset asserted during the update cycle
    do_reset();
    step();
    send(8'h01, 8'h05);
    step();
    send(8'h01, 8'h04);
    reset = 1'b1;
    #2;
    check("midrst_tready",  64'(axis_if.AXIS_IN_TREADY), 64'd0);
    check("midrst_strobe",  64'(event_strobe),  64'd0);
    check("midrst_count",   64'(event_count),   64'd0);
    check("midrst_pending", 64'(event_pending), 64'd0);
    @(posedge clk); #1;
    check("midrst_strobe_edge", 64'(event_strobe), 64'd0);
    do_reset();
`ifdef EVENT_DECODER_TIMESTAMP_EN
    check("ts_rst_id",   64'(last_event_id),   64'd0);
    check("ts_rst_time", 64'(last_event_time), 64'd0);
`endif
    step();
    send(8'h01, 8'h02);
    step();
    check("post_rst_strobe", 64'(event_strobe), 64'h02);
`ifdef EVENT_DECODER_TIMESTAMP_EN
    t1 = last_event_time;
    check("ts_id2", 64'(last_event_id), 64'd2);
    send(8'h01, 8'h03);
    step();
    tests++;
    if (!(last_event_time > t1)) begin
      fails++;
      $display("FAIL ts_increasing: got 0x%0h, expected above 0x%0h", last_event_time, t1);
    end
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      axis_if.AXIS_IN_TVALID = ($urandom_range(9) < 7);
      axis_if.AXIS_IN_TDATA  = mk(($urandom_range(3) != 0) ? 8'h01 : 8'($urandom),
                                  8'($urandom_range(10)));
      irq_enable    = NE'($urandom);
      pending_clear = ($urandom_range(3) == 0) ? NE'($urandom) : '0;
      counter_clear = ($urandom_range(40) == 0);
      step();
    end
    axis_if.AXIS_IN_TVALID = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
